// File: rtl/datasort_param_if.sv
// Ready/valid bundle between the data source, datasort_param and its consumer.
// idx_out and the IDXW parameter exist only when SORT_IDX_EN is defined.
interface datasort_param_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned W    = 8
`ifdef SORT_IDX_EN
    , parameter int unsigned IDXW = $clog2(N)
`endif
);
    logic           vld_in;
    logic           rdy_in;
    logic           mode;
    logic [N*W-1:0] din;
    logic           vld_out;
    logic           rdy_out;
    logic [N*W-1:0] dout;
`ifdef SORT_IDX_EN
    logic [N*IDXW-1:0] idx_out;

    modport master (output vld_in, mode, din, rdy_out, input rdy_in, vld_out, dout, idx_out);
    modport slave  (input vld_in, mode, din, rdy_out, output rdy_in, vld_out, dout, idx_out);
`else
    modport master (output vld_in, mode, din, rdy_out, input rdy_in, vld_out, dout);
    modport slave  (input vld_in, mode, din, rdy_out, output rdy_in, vld_out, dout);
`endif
endinterface

// File: rtl/datasort_param.sv
// N-lane W-bit unsigned sorter: odd-even transposition, one phase per clock, fixed N-cycle latency.
// SORT_IDX_EN adds a per-lane original-index tag that travels with its data (idx_out).
module datasort_param #(
    parameter int unsigned N    = 32,
    parameter int unsigned W    = 8
`ifdef SORT_IDX_EN
    , parameter int unsigned IDXW = $clog2(N)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    datasort_param_if.slave  bus
);
    localparam int unsigned  PW        = $clog2(N);
    localparam logic [PW-1:0] LastPhase = PW'(N - 1);

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  data_q [N];
    logic [W-1:0]  data_d [N];
    logic [W-1:0]  net_data [N];
    logic          rdy_in;
    logic          accept;
    logic          swap;
`ifdef SORT_IDX_EN
    logic [IDXW-1:0] idx_q [N];
    logic [IDXW-1:0] idx_d [N];
    logic [IDXW-1:0] net_idx [N];
`endif

    // One transposition phase; pairs of a phase are disjoint, so reading data_q is safe.
    always_comb begin
        net_data = data_q;
`ifdef SORT_IDX_EN
        net_idx  = idx_q;
`endif
        swap = 1'b0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (1'(i % 2) == phase_q[0]) begin
                // Strict compares keep equal keys in place, which makes the sort stable.
                swap = mode_q ? (data_q[i] < data_q[i+1]) : (data_q[i] > data_q[i+1]);
                if (swap) begin
                    net_data[i]   = data_q[i+1];
                    net_data[i+1] = data_q[i];
`ifdef SORT_IDX_EN
                    net_idx[i]    = idx_q[i+1];
                    net_idx[i+1]  = idx_q[i];
`endif
                end
            end
        end
    end

    always_comb begin
        rdy_in  = (state_q == StIdle) | ((state_q == StDone) & bus.rdy_out);
        accept  = bus.vld_in & rdy_in;
        state_d = state_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        data_d  = data_q;
`ifdef SORT_IDX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            StIdle: if (accept) state_d = StSort;
            StSort: begin
                data_d  = net_data;
`ifdef SORT_IDX_EN
                idx_d   = net_idx;
`endif
                phase_d = phase_q + 1'b1;
                if (phase_q == LastPhase) state_d = StDone;
            end
            StDone: if (bus.rdy_out) state_d = accept ? StSort : StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            mode_d  = bus.mode;
            phase_d = '0;
            for (int i = 0; i < int'(N); i++) begin
                data_d[i] = bus.din[i*W +: W];
`ifdef SORT_IDX_EN
                idx_d[i]  = IDXW'(i);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            mode_q  <= 1'b0;
            data_q  <= '{default: '0};
`ifdef SORT_IDX_EN
            idx_q   <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
`ifdef SORT_IDX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    logic [N*W-1:0] dout_flat;
    always_comb begin
        dout_flat = '0;
        for (int i = 0; i < int'(N); i++) dout_flat[i*W +: W] = data_q[i];
    end

`ifdef SORT_IDX_EN
    logic [N*IDXW-1:0] idx_flat;
    always_comb begin
        idx_flat = '0;
        for (int i = 0; i < int'(N); i++) idx_flat[i*IDXW +: IDXW] = idx_q[i];
    end
    assign bus.idx_out = idx_flat;
`endif

    assign bus.rdy_in  = rdy_in;
    assign bus.vld_out = (state_q == StDone);
    assign bus.dout    = dout_flat;
endmodule

// File: tb/tb_datasort_param.sv
// Directed bench for datasort_param: a 32x8 instance for the main scenarios and a 4x8 instance
// for the stability / index-tag case.
module tb_datasort_param;
    localparam int unsigned N  = 32;
    localparam int unsigned W  = 8;
    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    datasort_param_if #(.N(N),  .W(W)) bus  ();
    datasort_param_if #(.N(NS), .W(W)) bus4 ();

    datasort_param #(.N(N),  .W(W)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    datasort_param #(.N(NS), .W(W)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [N*W-1:0] d, input logic m);
        bus.din    = d;
        bus.mode   = m;
        bus.vld_in = 1'b1;
        step();
        bus.vld_in = 1'b0;
    endtask

    task automatic wait32(output int edges);
        edges = 0;
        while (bus.vld_out !== 1'b1 && edges < 200) begin
            step();
            edges++;
        end
    endtask

    task automatic pop32();
        bus.rdy_out = 1'b1;
        step();
        bus.rdy_out = 1'b0;
    endtask

    task automatic test_reset();
        logic [N*W-1:0] d;
        int seen;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if (bus.vld_out !== 1'b0 || bus.rdy_in !== 1'b1 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_init: vld_out=%b rdy_in=%b dout=%h, want 0 1 0",
                     bus.vld_out, bus.rdy_in, bus.dout);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < int'(N); i++) d[i*W +: W] = W'(i + 40);
        send32(d, 1'b0);
        repeat (5) step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.vld_out !== 1'b0 || bus.rdy_in !== 1'b1 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_mid_sort: vld_out=%b rdy_in=%b dout=%h, want 0 1 0",
                     bus.vld_out, bus.rdy_in, bus.dout);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (bus.vld_out === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_vld: vld_out high %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_ascending();
        logic [N*W-1:0] d, exp;
        int edges;
        for (int i = 0; i < int'(N); i++) begin
            d[i*W +: W]   = W'(31 - i);
            exp[i*W +: W] = W'(i);
        end
        send32(d, 1'b0);
        wait32(edges);
        checks++;
        if (edges != int'(N)) begin
            errors++;
            $display("FAIL asc_latency: got %0d edges, want %0d", edges, N);
        end
        checks++;
        if (bus.dout !== exp) begin
            errors++;
            $display("FAIL asc_data: got %h want %h", bus.dout, exp);
        end
        pop32();
        checks++;
        if (bus.vld_out !== 1'b0 || bus.rdy_in !== 1'b1) begin
            errors++;
            $display("FAIL asc_pop: vld_out=%b rdy_in=%b, want 0 1", bus.vld_out, bus.rdy_in);
        end
    endtask

    task automatic test_descending();
        logic [N*W-1:0] d, exp;
        int edges, bad;
        for (int i = 0; i < int'(N); i++) begin
            d[i*W +: W]   = W'(i);
            exp[i*W +: W] = W'(31 - i);
        end
        send32(d, 1'b1);
        // Changes after acceptance must not leak into the sort.
        bus.mode = 1'b0;
        bus.din  = {N{8'h5A}};
        wait32(edges);
        checks++;
        if (edges != int'(N) || bus.dout !== exp) begin
            errors++;
            $display("FAIL desc_data: got %h (%0d edges) want %h (%0d edges)",
                     bus.dout, edges, exp, N);
        end
        pop32();
        for (int i = 0; i < int'(N); i++) d[i*W +: W] = W'((i * 53 + 17) % 251 + 1);
        d[7*W +: W]  = 8'd0;
        d[25*W +: W] = 8'd255;
        send32(d, 1'b1);
        wait32(edges);
        checks++;
        if (bus.dout[0 +: W] !== 8'd255 || bus.dout[31*W +: W] !== 8'd0) begin
            errors++;
            $display("FAIL desc_extremes: lane0=%0d lane31=%0d, want 255 0",
                     bus.dout[0 +: W], bus.dout[31*W +: W]);
        end
        bad = 0;
        for (int i = 0; i < int'(N) - 1; i++)
            if (bus.dout[i*W +: W] < bus.dout[(i+1)*W +: W]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL desc_order: %0d out-of-order pairs, want 0", bad);
        end
        pop32();
    endtask

    task automatic test_idx();
        logic [NS*W-1:0] exp;
        int edges;
        exp = {8'd5, 8'd5, 8'd3, 8'd3};
        bus4.din    = {8'd3, 8'd5, 8'd3, 8'd5};
        bus4.mode   = 1'b0;
        bus4.vld_in = 1'b1;
        step();
        bus4.vld_in = 1'b0;
        edges = 0;
        while (bus4.vld_out !== 1'b1 && edges < 50) begin
            step();
            edges++;
        end
        checks++;
        if (edges != int'(NS) || bus4.dout !== exp) begin
            errors++;
            $display("FAIL idx_data: got %h (%0d edges) want %h (%0d edges)",
                     bus4.dout, edges, exp, NS);
        end
`ifdef SORT_IDX_EN
        begin
            logic [7:0] exp_idx;
            exp_idx = {2'd2, 2'd0, 2'd3, 2'd1};
            checks++;
            if (bus4.idx_out !== exp_idx) begin
                errors++;
                $display("FAIL idx_tags: got %h want %h", bus4.idx_out, exp_idx);
            end
        end
`endif
        bus4.rdy_out = 1'b1;
        step();
        bus4.rdy_out = 1'b0;
        checks++;
        if (bus4.vld_out !== 1'b0) begin
            errors++;
            $display("FAIL idx_pop: vld_out=%b want 0", bus4.vld_out);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] d, exp;
        int edges, rdy_seen, bad;
        for (int i = 0; i < int'(N); i++) begin
            d[i*W +: W]   = W'(i ^ 11);
            exp[i*W +: W] = W'(i);
        end
        send32(d, 1'b0);
        bus.vld_in = 1'b1;
        bus.din    = {N{8'hAA}};
        edges = 0;
        rdy_seen = 0;
        while (bus.vld_out !== 1'b1 && edges < 200) begin
            if (bus.rdy_in !== 1'b0) rdy_seen++;
            step();
            edges++;
        end
        checks++;
        if (rdy_seen != 0 || edges != int'(N)) begin
            errors++;
            $display("FAIL bp_sort_ignore: rdy_in high %0d cycles, %0d edges; want 0, %0d",
                     rdy_seen, edges, N);
        end
        bad = 0;
        repeat (10) begin
            if (bus.vld_out !== 1'b1 || bus.dout !== exp || bus.rdy_in !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (dout=%h)", bad, bus.dout);
        end
        bus.vld_in = 1'b0;
        pop32();
        checks++;
        if (bus.vld_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop: vld_out=%b want 0", bus.vld_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] a, exp_a, b, exp_b;
        int edges;
        for (int i = 0; i < int'(N); i++) begin
            a[i*W +: W]     = W'(31 - i);
            exp_a[i*W +: W] = W'(i);
            b[i*W +: W]     = W'((i * 7) % 32);
            exp_b[i*W +: W] = W'(31 - i);
        end
        send32(a, 1'b0);
        wait32(edges);
        checks++;
        if (bus.dout !== exp_a) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", bus.dout, exp_a);
        end
        bus.din     = b;
        bus.mode    = 1'b1;
        bus.vld_in  = 1'b1;
        bus.rdy_out = 1'b1;
        step();
        bus.vld_in  = 1'b0;
        bus.rdy_out = 1'b0;
        checks++;
        if (bus.vld_out !== 1'b0 || bus.rdy_in !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: vld_out=%b rdy_in=%b, want 0 0", bus.vld_out, bus.rdy_in);
        end
        wait32(edges);
        checks++;
        if (edges != int'(N) || bus.dout !== exp_b) begin
            errors++;
            $display("FAIL b2b_second: got %h (%0d edges) want %h (%0d edges)",
                     bus.dout, edges, exp_b, N);
        end
        pop32();
    endtask

    initial begin
        bus.vld_in   = 1'b0;
        bus.rdy_out  = 1'b0;
        bus.mode     = 1'b0;
        bus.din      = '0;
        bus4.vld_in  = 1'b0;
        bus4.rdy_out = 1'b0;
        bus4.mode    = 1'b0;
        bus4.din     = '0;
        test_reset();
        test_ascending();
        test_descending();
        test_idx();
        test_backpressure();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
